// File: rtl/alien_fleet_pkg.sv
// Shared widths, playfield defaults and state types for the invaders
// alien fleet and the blocks that talk to it.
package invaders_pkg;

    localparam int X_W            = 5;
    localparam int Y_W            = 4;
    localparam int FIELD_COLS_DEF = 20;
    localparam int SHIP_ROW_DEF   = 15;

    typedef enum logic [1:0] {
        S_RUN,
        S_CLEARED,
        S_LANDED
    } state_e;

    typedef enum logic {
        DIR_RIGHT,
        DIR_LEFT
    } dir_e;

endpackage

// File: rtl/alien_fleet_if.sv
// Bullet coordinates in from the player, fleet state out to the
// player (hit) and the renderer.
interface alien_fleet_if;
    import invaders_pkg::*;

    logic [X_W-1:0] i_bullet_x;
    logic [Y_W-1:0] i_bullet_y;
    logic           o_hit;
    logic [31:0]    o_alive;
    logic [X_W-1:0] o_fleet_x;
    logic [Y_W-1:0] o_fleet_y;
    logic [7:0]     o_score;
    logic           o_cleared;
    logic           o_landed;

    modport master (
        output i_bullet_x, i_bullet_y,
        input  o_hit, o_alive, o_fleet_x, o_fleet_y,
        input  o_score, o_cleared, o_landed
    );

    modport slave (
        input  i_bullet_x, i_bullet_y,
        output o_hit, o_alive, o_fleet_x, o_fleet_y,
        output o_score, o_cleared, o_landed
    );

endinterface

// File: rtl/alien_fleet_extents.sv
// Lowest/highest alive column and highest alive row of the formation,
// used by the march logic to find the fleet's effective edges.
module fleet_extents #(
    parameter int ROWS = 4,
    parameter int COLS = 8
) (
    input  logic [31:0] alive_i,
    output logic [4:0]  lc_o,
    output logic [4:0]  rc_o,
    output logic [4:0]  br_o
);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_i[r*COLS+c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        lc_o = '0;
        rc_o = '0;
        br_o = '0;
        for (int c = COLS - 1; c >= 0; c--)
            if (col_any[c]) lc_o = 5'(c);
        for (int c = 0; c < COLS; c++)
            if (col_any[c]) rc_o = 5'(c);
        for (int r = 0; r < ROWS; r++)
            if (row_any[r]) br_o = 5'(r);
    end

endmodule

// File: rtl/alien_fleet.sv
// Alien formation: bullet hit detection, alive bitmap, score, timed
// march with edge descend, and cleared/landed end-of-wave states.
module alien_fleet
    import invaders_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 8,
    parameter int FIELD_COLS  = FIELD_COLS_DEF,
    parameter int SHIP_ROW    = SHIP_ROW_DEF,
    parameter int STEP_CYCLES = 12_500_000
) (
    input logic          i_clk_25MHz,
    input logic          i_reset,
    alien_fleet_if.slave bus
);

    localparam int NA    = ROWS * COLS;
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [31:0] ALL_ALIVE = 32'((64'd1 << NA) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [X_W-1:0]   fx_q, fx_d;
    logic [Y_W-1:0]   fy_q, fy_d;
    logic [31:0]      alive_q, alive_d;
    logic [7:0]       score_q, score_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       dx, dy;
    logic [4:0]       hit_idx, lc, rc, br;
    logic             tick, descend, land;

    fleet_extents #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_ext (
        .alive_i(alive_q),
        .lc_o   (lc),
        .rc_o   (rc),
        .br_o   (br)
    );

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    // 6-bit differences: a negative offset shows up as bit 5 set.
    always_comb begin
        dx      = {1'b0, bus.i_bullet_x} - {1'b0, fx_q};
        dy      = {2'b00, bus.i_bullet_y} - {2'b00, fy_q};
        hit_idx = 5'(dy[4:0] * 5'(COLS) + 5'(dx[4:1]));
        hit_d   = (state_q == S_RUN) && !dx[5] && !dx[0]
                  && (dx[4:0] <= 5'(2 * (COLS - 1)))
                  && !dy[5] && (dy[4:0] < 5'(ROWS))
                  && alive_q[hit_idx];
    end

    always_comb begin
        alive_d = alive_q;
        score_d = score_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        dir_d   = dir_q;
        descend = 1'b0;
        if (hit_d) begin
            alive_d[hit_idx] = 1'b0;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end
        // Extents come from alive_q, so a same-cycle kill does not move the edge.
        if (state_q == S_RUN && tick && alive_q != '0) begin
            if (dir_q == DIR_RIGHT) begin
                if (int'(fx_q) + 2 * int'(rc) == FIELD_COLS - 1) descend = 1'b1;
                else fx_d = fx_q + X_W'(1);
            end else begin
                if (fx_q == '0 || int'(fx_q) + 2 * int'(lc) == 0) descend = 1'b1;
                else fx_d = fx_q - X_W'(1);
            end
            if (descend) begin
                fy_d  = fy_q + Y_W'(1);
                dir_d = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
            end
        end
        land = descend && (int'(fy_q) + 1 + int'(br) == SHIP_ROW - 1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (alive_q == '0) state_d = S_CLEARED;
                else if (land && alive_d != '0) state_d = S_LANDED;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        bus.o_hit     = hit_q;
        bus.o_alive   = alive_q;
        bus.o_fleet_x = fx_q;
        bus.o_fleet_y = fy_q;
        bus.o_score   = score_q;
        bus.o_cleared = (state_q == S_CLEARED);
        bus.o_landed  = (state_q == S_LANDED);
    end

    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) state_q <= S_RUN;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            dir_q   <= DIR_RIGHT;
            fx_q    <= '0;
            fy_q    <= '0;
            alive_q <= ALL_ALIVE;
            score_q <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            dir_q   <= dir_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            alive_q <= alive_d;
            score_q <= score_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alien_fleet.sv
// Directed scenarios plus randomized bullets for alien_fleet, checked
// against a behavioural model of the formation rules.
module tb_alien_fleet;

    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int FIELD = 20;
    localparam int SHIP  = 15;
    localparam int STEP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    alien_fleet_if bus();

    alien_fleet #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .FIELD_COLS (FIELD),
        .SHIP_ROW   (SHIP),
        .STEP_CYCLES(STEP)
    ) dut (
        .i_clk_25MHz(clk),
        .i_reset    (rst),
        .bus        (bus)
    );

    always #20 clk = ~clk;

    logic [31:0] m_alive;
    int m_fx, m_fy, m_score, m_cnt, m_state;
    bit m_right, m_hit;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_alive = 32'hFFFF_FFFF;
        m_fx = 0; m_fy = 0; m_score = 0; m_cnt = 0;
        m_state = 0; m_right = 1'b1; m_hit = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then compare outputs.
    task automatic step(input int bx_in, input int by_in, input bit r_in);
        int bx, by, dx, dy, lc, rc, br, idx;
        bit desc;
        bx = bx_in & 31;
        by = by_in & 15;
        bus.i_bullet_x = 5'(bx);
        bus.i_bullet_y = 4'(by);
        rst = r_in;
        m_hit = 1'b0;
        desc = 1'b0;
        br = 0; lc = COLS; rc = -1; idx = 0;
        if (r_in) begin
            model_reset();
        end else begin
            if (m_state == 0 && m_alive == 0) begin
                m_state = 1;
            end else if (m_state == 0) begin
                dx = bx - m_fx;
                dy = by - m_fy;
                if (dx >= 0 && dx <= 2 * (COLS - 1) && dx % 2 == 0 &&
                    dy >= 0 && dy < ROWS) begin
                    idx = dy * COLS + dx / 2;
                    m_hit = m_alive[idx];
                end
                if (m_cnt == STEP - 1) begin
                    br = -1;
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            if (m_alive[r*COLS+c]) begin
                                if (c < lc) lc = c;
                                if (c > rc) rc = c;
                                if (r > br) br = r;
                            end
                    if (m_right) begin
                        if (m_fx + 2 * rc == FIELD - 1) desc = 1'b1;
                        else m_fx++;
                    end else begin
                        if (m_fx == 0 || m_fx + 2 * lc == 0) desc = 1'b1;
                        else m_fx--;
                    end
                    if (desc) begin
                        m_fy++;
                        m_right = !m_right;
                    end
                end
                if (m_hit) begin
                    m_alive[idx] = 1'b0;
                    if (m_score < 255) m_score++;
                end
                if (desc && m_fy + br == SHIP - 1 && m_alive != 0) m_state = 2;
            end
            m_cnt = (m_cnt + 1) % STEP;
        end
        @(posedge clk);
        #1;
        chk("hit", 32'(bus.o_hit), 32'(m_hit));
        chk("alive", bus.o_alive, m_alive);
        chk("fleet_x", 32'(bus.o_fleet_x), m_fx);
        chk("fleet_y", 32'(bus.o_fleet_y), m_fy);
        chk("score", 32'(bus.o_score), m_score);
        chk("cleared", 32'(bus.o_cleared), 32'(m_state == 1));
        chk("landed", 32'(bus.o_landed), 32'(m_state == 2));
    endtask

    task automatic do_reset();
        step(31, 15, 1'b1);
        step(31, 15, 1'b1);
    endtask

    initial begin
        int ex[11] = '{2, 3, 4, 5, 5, 4, 3, 2, 1, 0, 0};
        int ey[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2};
        int ord[32];
        int sx, sy, n, j, t, bx, by;

        model_reset();
        bus.i_bullet_x = 5'd31;
        bus.i_bullet_y = 4'd15;

        // Reset values, gap/miss, direct hit and hold
        do_reset();
        chk("rst_alive", bus.o_alive, 32'hFFFF_FFFF);
        chk("rst_x", 32'(bus.o_fleet_x), 0);
        chk("rst_y", 32'(bus.o_fleet_y), 0);
        chk("rst_score", 32'(bus.o_score), 0);
        chk("rst_hit", 32'(bus.o_hit), 0);
        step(3, 1, 1'b0);
        chk("gap_hit", 32'(bus.o_hit), 0);
        chk("gap_alive", bus.o_alive, 32'hFFFF_FFFF);
        step(2, 4, 1'b0);
        chk("miss_hit", 32'(bus.o_hit), 0);
        step(2, 1, 1'b0);
        chk("direct_hit", 32'(bus.o_hit), 1);
        chk("direct_alive", bus.o_alive, 32'hFFFF_FDFF);
        chk("direct_score", 32'(bus.o_score), 1);
        step(2, 1, 1'b0);
        chk("hold_hit", 32'(bus.o_hit), 0);
        chk("hold_score", 32'(bus.o_score), 1);

        // Kill column 0, last kill lands on a tick cycle, then march
        do_reset();
        step(0, 1, 1'b0);
        step(0, 2, 1'b0);
        step(0, 3, 1'b0);
        step(0, 0, 1'b0);
        chk("sim_hit", 32'(bus.o_hit), 1);
        chk("sim_alive", bus.o_alive, 32'hFEFE_FEFE);
        chk("sim_x", 32'(bus.o_fleet_x), 1);
        for (int k = 0; k < 11; k++) begin
            for (int s = 0; s < STEP; s++) step(31, 15, 1'b0);
            chk("march_x", 32'(bus.o_fleet_x), ex[k]);
            chk("march_y", 32'(bus.o_fleet_y), ey[k]);
        end

        // Run on until the fleet lands
        n = 0;
        while (!bus.o_landed && n < 2000) begin
            step(31, 15, 1'b0);
            n++;
        end
        chk("landed", 32'(bus.o_landed), 1);
        chk("land_y", 32'(bus.o_fleet_y), 11);
        sx = m_fx;
        sy = m_fy;
        for (int s = 0; s < 8; s++) begin
            step(sx + 2, sy, 1'b0);
            chk("land_nohit", 32'(bus.o_hit), 0);
        end
        chk("land_frozen_x", 32'(bus.o_fleet_x), sx);
        chk("land_frozen_y", 32'(bus.o_fleet_y), 11);

        // Kill every alien in shuffled order
        do_reset();
        for (int i = 0; i < 32; i++) ord[i] = i;
        for (int i = 31; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < 32; i++) begin
            step(m_fx + 2 * (ord[i] % COLS), m_fy + ord[i] / COLS, 1'b0);
            chk("clr_hit", 32'(bus.o_hit), 1);
        end
        chk("clr_score", 32'(bus.o_score), 32);
        chk("clr_early", 32'(bus.o_cleared), 0);
        step(31, 15, 1'b0);
        chk("cleared", 32'(bus.o_cleared), 1);
        sx = m_fx;
        sy = m_fy;
        for (int s = 0; s < 12; s++) step(31, 15, 1'b0);
        chk("clr_frozen_x", 32'(bus.o_fleet_x), sx);
        chk("clr_frozen_y", 32'(bus.o_fleet_y), sy);

        // Random bullets, half aimed at alien cells, rare mid-run resets
        for (int ep = 0; ep < 3; ep++) begin
            do_reset();
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(1, 0) == 1) begin
                    bx = m_fx + 2 * $urandom_range(COLS - 1, 0);
                    by = m_fy + $urandom_range(ROWS - 1, 0);
                end else begin
                    bx = $urandom_range(31, 0);
                    by = $urandom_range(15, 0);
                end
                step(bx, by, $urandom_range(199, 0) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
